rv_timer: RTL and testbench

Memory-mapped 32-bit interval timer that sits on the rv_core data bus as a responder, alongside the serial peripheral, at base 0xffff0040 (32-byte window). It decodes core reads and byte-masked writes, runs a prescaled up-counter with compare match and optional auto-reload, and raises a level interrupt to the core. Read data returns one cycle after the read strobe, matching the registered read-select mux in the top level.

---
 rtl/rv_timer.sv | 117 +++++++++++
 tb/tb_rv_timer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_timer.sv
// Memory-mapped 32-bit interval timer: prescaled up-counter with compare match,
// optional auto-reload and a level interrupt, read data registered one cycle.
module rv_timer #(
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        cs,
  input  logic [4:0]  adr,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_CTRL  = 3'd0,
    REG_STAT  = 3'd1,
    REG_COUNT = 3'd2,
    REG_CMP   = 3'd3,
    REG_PRESC = 3'd4
  } reg_e;

  logic [2:0]       ctrl_q, ctrl_d;   // {IE, AR, EN}
  logic             mf_q, mf_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]      dr_q, dr_d;

  logic       wr_acc, rd_acc, tick, match;
  reg_e       sel;
  logic [31:0] presc_ext, presc_wr_val;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wr_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  assign sel          = reg_e'(adr[4:2]);
  assign wr_acc       = cs & rdy & (we != 4'h0);
  assign rd_acc       = cs & rdy & re;
  assign tick         = ctrl_q[0] && (pre_cnt_q == presc_q);
  // Match compares the registered COUNT/CMP, so same-cycle bus writes never affect it.
  assign match        = tick && (count_q == cmp_q);
  assign presc_ext    = 32'(presc_q);
  assign presc_wr_val = byte_merge(presc_ext, dw, we);

  // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
  always_comb begin
    ctrl_d    = ctrl_q;
    mf_d      = mf_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    presc_d   = presc_q;
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    dr_d      = dr_q;

    if (wr_acc && sel == REG_CTRL && we[0]) ctrl_d = dw[2:0];

    // A match in the same cycle as a W1C keeps the flag set.
    if (match)                                        mf_d = 1'b1;
    else if (wr_acc && sel == REG_STAT && we[0] && dw[0]) mf_d = 1'b0;

    if (wr_acc && sel == REG_COUNT)  count_d = byte_merge(count_q, dw, we);
    else if (tick)                   count_d = (match && ctrl_q[1]) ? 32'h0 : count_q + 32'h1;

    if (wr_acc && sel == REG_CMP)    cmp_d = byte_merge(cmp_q, dw, we);
    if (wr_acc && sel == REG_PRESC)  presc_d = presc_wr_val[PRE_W-1:0];

    if (!ctrl_q[0] || tick || (wr_acc && sel == REG_PRESC)) pre_cnt_d = '0;

    if (rd_acc) begin
      case (sel)
        REG_CTRL:  dr_d = {29'h0, ctrl_q};
        REG_STAT:  dr_d = {31'h0, mf_q};
        REG_COUNT: dr_d = count_q;
        REG_CMP:   dr_d = cmp_q;
        REG_PRESC: dr_d = presc_ext;
        default:   dr_d = 32'h0;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      ctrl_q    <= '0;
      mf_q      <= 1'b0;
      count_q   <= '0;
      cmp_q     <= 32'hffff_ffff;
      presc_q   <= '0;
      pre_cnt_q <= '0;
      dr_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      mf_q      <= mf_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      presc_q   <= presc_d;
      pre_cnt_q <= pre_cnt_d;
      dr_q      <= dr_d;
    end
  end

  assign dr  = dr_q;
  assign irq = mf_q & ctrl_q[2];

endmodule

// File: tb/tb_rv_timer.sv
// Self-checking bench for rv_timer: directed boundary scenarios plus a randomized
// bus run compared cycle-by-cycle against a register-level reference model.
module tb_rv_timer;
  localparam int PRE_W = 16;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic        cs = 1'b0, rdy = 1'b0, re = 1'b0;
  logic [4:0]  adr = '0;
  logic [3:0]  we = '0;
  logic [31:0] dw = '0;
  logic [31:0] dr;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [2:0]       m_ctrl;
  logic             m_mf;
  logic [31:0]      m_count, m_cmp, m_dr;
  logic [PRE_W-1:0] m_presc, m_phase;

  logic [31:0] rst_tbl [8] = '{32'h0, 32'h0, 32'h0, 32'hffff_ffff, 32'h0, 32'h0, 32'h0, 32'h0};

  rv_timer #(.PRE_W(PRE_W)) dut (
    .clk(clk), .xreset(xreset), .cs(cs), .adr(adr), .rdy(rdy),
    .we(we), .re(re), .dw(dw), .dr(dr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ctrl = '0; m_mf = 1'b0; m_count = '0; m_cmp = 32'hffff_ffff;
    m_presc = '0; m_phase = '0; m_dr = '0;
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return {29'h0, m_ctrl};
      1: return {31'h0, m_mf};
      2: return m_count;
      3: return m_cmp;
      4: return 32'(m_presc);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one bus cycle, advance the model across the edge, return #1 after it.
  task automatic drive(input logic c, input logic r_dy, input logic [4:0] a,
                       input logic [3:0] w, input logic r, input logic [31:0] d);
    logic acc, wr, rdq, tick, match;
    int idx;
    logic [31:0] n_count, n_cmp, n_dr, tmp;
    logic [2:0] n_ctrl;
    logic n_mf;
    logic [PRE_W-1:0] n_presc, n_phase;
    cs = c; rdy = r_dy; adr = a; we = w; re = r; dw = d;
    acc = c & r_dy; wr = acc && (w != 4'h0); rdq = acc && r; idx = int'(a[4:2]);
    tick  = m_ctrl[0] && (m_phase == m_presc);
    match = tick && (m_count == m_cmp);
    n_dr = rdq ? m_read(idx) : m_dr;
    n_count = m_count;
    if (tick) n_count = (match && m_ctrl[1]) ? 32'h0 : m_count + 32'h1;
    if (wr && idx == 2) n_count = bytes_merge(m_count, d, w);
    n_mf = m_mf;
    if (wr && idx == 1 && w[0] && d[0]) n_mf = 1'b0;
    if (match) n_mf = 1'b1;
    n_ctrl = (wr && idx == 0 && w[0]) ? d[2:0] : m_ctrl;
    n_cmp = (wr && idx == 3) ? bytes_merge(m_cmp, d, w) : m_cmp;
    tmp = bytes_merge(32'(m_presc), d, w);
    n_presc = (wr && idx == 4) ? tmp[PRE_W-1:0] : m_presc;
    if (!m_ctrl[0] || tick) n_phase = '0;
    else                    n_phase = m_phase + PRE_W'(1);
    if (wr && idx == 4) n_phase = '0;
    @(posedge clk);
    m_dr = n_dr; m_count = n_count; m_mf = n_mf; m_ctrl = n_ctrl;
    m_cmp = n_cmp; m_presc = n_presc; m_phase = n_phase;
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, 4'hf, 1'b0, d);
  endtask

  task automatic rd_reg(input logic [4:0] a);
    drive(1'b1, 1'b1, a, 4'h0, 1'b1, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 5'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    xreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    xreset = 1'b1;
    model_reset();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (dr !== 32'h0) begin failures++; $display("FAIL reset_dr got=%h exp=0", dr); end
    for (int i = 0; i < 8; i++) begin
      rd_reg(5'(i * 4));
      checks++;
      if (dr !== rst_tbl[i]) begin
        failures++; $display("FAIL reset_read off=%0h got=%h exp=%h", i * 4, dr, rst_tbl[i]);
      end
    end
  endtask

  task automatic test_byte_write();
    wr_reg(5'h08, 32'h0);
    rd_reg(5'h0c);
    drive(1'b1, 1'b1, 5'h08, 4'b0101, 1'b0, 32'h1234_5678);
    checks++;
    if (dr !== 32'hffff_ffff) begin failures++; $display("FAIL dr_hold got=%h exp=ffffffff", dr); end
    rd_reg(5'h08);
    checks++;
    if (dr !== 32'h0034_0078) begin failures++; $display("FAIL byte_write got=%h exp=00340078", dr); end
    idle();
    checks++;
    if (dr !== 32'h0034_0078) begin failures++; $display("FAIL dr_idle_hold got=%h exp=00340078", dr); end
    drive(1'b1, 1'b1, 5'h08, 4'hf, 1'b1, 32'haaaa_5555);
    checks++;
    if (dr !== 32'h0034_0078) begin failures++; $display("FAIL rd_wr_same got=%h exp=00340078", dr); end
    rd_reg(5'h08);
    checks++;
    if (dr !== 32'haaaa_5555) begin failures++; $display("FAIL rd_after_wr got=%h exp=aaaa5555", dr); end
  endtask

  task automatic test_period();
    int rises[$];
    logic prev_irq, clear_next;
    logic [31:0] exp;
    wr_reg(5'h10, 32'd3);
    wr_reg(5'h0c, 32'd5);
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h04, 32'd1);
    wr_reg(5'h00, 32'h7);
    prev_irq = 1'b0; clear_next = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (clear_next) drive(1'b1, 1'b1, 5'h04, 4'h1, 1'b0, 32'h1);
      else begin
        rd_reg(5'h08);
        exp = 32'(((i - 1) / 4) % 6);
        checks++;
        if (dr !== exp) begin failures++; $display("FAIL period_count cyc=%0d got=%h exp=%h", i, dr, exp); end
      end
      checks++;
      if (irq !== (m_mf & m_ctrl[2])) begin
        failures++; $display("FAIL period_irq cyc=%0d got=%b exp=%b", i, irq, m_mf & m_ctrl[2]);
      end
      if (irq && !prev_irq) rises.push_back(i);
      clear_next = irq;
      prev_irq = irq;
    end
    checks++;
    if (rises.size() != 2 || rises[0] != 24 || rises[1] != 48) begin
      failures++; $display("FAIL period_rises got_n=%0d exp=2 (at 24,48)", rises.size());
    end
    wr_reg(5'h00, 32'h0);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4] = '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1};
    wr_reg(5'h04, 32'h1);
    wr_reg(5'h10, 32'h0);
    wr_reg(5'h0c, 32'h0);
    wr_reg(5'h08, 32'hffff_fffe);
    wr_reg(5'h00, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd_reg(5'h08);
      checks++;
      if (dr !== exp_seq[i]) begin failures++; $display("FAIL wrap_count step=%0d got=%h exp=%h", i, dr, exp_seq[i]); end
    end
    rd_reg(5'h04);
    checks++;
    if (dr !== 32'h1) begin failures++; $display("FAIL wrap_mf got=%h exp=1", dr); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL wrap_irq_ie0 got=%b exp=0", irq); end
    wr_reg(5'h00, 32'h0);
  endtask

  task automatic test_w1c_race();
    wr_reg(5'h04, 32'h1);
    wr_reg(5'h10, 32'h0);
    wr_reg(5'h0c, 32'd3);
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h00, 32'h7);
    repeat (3) idle();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_pre_irq got=%b exp=0", irq); end
    drive(1'b1, 1'b1, 5'h04, 4'h1, 1'b0, 32'h1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL race_set_wins got=%b exp=1", irq); end
    drive(1'b1, 1'b1, 5'h04, 4'h1, 1'b0, 32'h1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_w1c got=%b exp=0", irq); end
    wr_reg(5'h00, 32'h3);
    idle();
    idle();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_ie0_irq got=%b exp=0", irq); end
    rd_reg(5'h04);
    checks++;
    if (dr !== 32'h1) begin failures++; $display("FAIL race_ie0_mf got=%h exp=1", dr); end
    wr_reg(5'h00, 32'h0);
  endtask

  task automatic test_random();
    logic c, r_dy, r;
    logic [4:0] a;
    logic [3:0] w;
    logic [31:0] d;
    for (int i = 0; i < 800; i++) begin
      c    = ($urandom_range(0, 9) != 0);
      r_dy = ($urandom_range(0, 7) != 0);
      a    = 5'($urandom_range(0, 31));
      w    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      r    = 1'($urandom);
      d    = $urandom;
      case (a[4:2])
        3'd2: if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 10);
        3'd3: d = $urandom_range(0, 12);
        3'd4: d = $urandom_range(0, 3);
        default: ;
      endcase
      drive(c, r_dy, a, w, r, d);
      checks++;
      if (dr !== m_dr) begin failures++; $display("FAIL rand_dr cyc=%0d got=%h exp=%h", i, dr, m_dr); end
      checks++;
      if (irq !== (m_mf & m_ctrl[2])) begin
        failures++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_mf & m_ctrl[2]);
      end
    end
  endtask

  task automatic test_async_reset();
    wr_reg(5'h00, 32'h0);
    wr_reg(5'h04, 32'h1);
    wr_reg(5'h10, 32'h0);
    wr_reg(5'h0c, 32'h0);
    wr_reg(5'h08, 32'h0);
    wr_reg(5'h00, 32'h7);
    rd_reg(5'h00);
    checks++;
    if (irq !== 1'b1 || dr !== 32'h7) begin
      failures++; $display("FAIL arst_pre got irq=%b dr=%h exp irq=1 dr=7", irq, dr);
    end
    idle();
    #2 xreset = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++;
    if (dr !== 32'h0) begin failures++; $display("FAIL arst_dr got=%h exp=0", dr); end
    repeat (2) @(negedge clk);
    xreset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      rd_reg(5'(i * 4));
      checks++;
      if (dr !== rst_tbl[i]) begin
        failures++; $display("FAIL arst_read off=%0h got=%h exp=%h", i * 4, dr, rst_tbl[i]);
      end
    end
    repeat (5) idle();
    rd_reg(5'h08);
    checks++;
    if (dr !== 32'h0) begin failures++; $display("FAIL arst_static got=%h exp=0", dr); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byte_write();
    test_period();
    test_wrap();
    test_w1c_race();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
